// File: rtl/snapshot_pkg.sv
// snapshot_pkg
// Shared definitions for the BRAM snapshot writer:
//   - controller state encoding (2-bit, legacy-compatible constants)
//   - clamp_len(): maps a requested capture length onto 1..2**aw
package snapshot_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Zero or oversize requests mean "fill the whole buffer".
    function automatic int unsigned clamp_len(input int unsigned n, input int unsigned aw);
        int unsigned depth;
        depth = 32'd1 << aw;
        if (n == 0 || n > depth)
            return depth;
        return n;
    endfunction

endpackage

// File: rtl/snapshot_ctrl_fsm.sv
// snapshot_ctrl_fsm
// Capture controller: state, latched length, busy/done flags and the
// written-sample counter.
// Ports:
//   axi_clock, rst_n           clock, async active-low reset
//   arm, abort                 single-cycle control pulses (abort wins)
//   trig_en, ext_trig          trigger enable / trigger level
//   din_valid                  sample strobe
//   num_samples                capture length, latched on an accepted arm
//   take                       comb: this cycle's sample is stored
//   busy, done                 registered status flags
//   wr_count                   samples written; doubles as next write address
module snapshot_ctrl_fsm
    import snapshot_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  axi_clock,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trig_en,
    input  logic                  ext_trig,
    input  logic                  din_valid,
    input  logic [ADDR_WIDTH:0]   num_samples,
    output logic                  take,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   wr_count
);

    localparam int unsigned LW = ADDR_WIDTH + 1;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [LW-1:0] len_q;
    logic          arm_ok;
    logic          last;

    always_comb begin
        arm_ok = 1'b0;
        take   = 1'b0;
        last   = 1'b0;
        if (!abort) begin
            arm_ok = arm && (state_q == ST_IDLE || state_q == ST_DONE);
            // The triggering sample itself is the first stored sample.
            take   = din_valid &&
                     ((state_q == ST_ARMED && ext_trig) || state_q == ST_CAPTURE);
        end
        last = take && ((wr_count + LW'(1)) == len_q);
    end

    always_comb begin
        state_d = state_q;
        if (abort)
            state_d = ST_IDLE;
        else if (arm_ok)
            state_d = trig_en ? ST_ARMED : ST_CAPTURE;
        else if (take)
            state_d = last ? ST_DONE : ST_CAPTURE;
    end

    always_ff @(posedge axi_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_count <= '0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
            if (arm_ok) begin
                len_q    <= LW'(clamp_len(32'(num_samples), ADDR_WIDTH));
                done     <= 1'b0;
                wr_count <= '0;
            end else if (take) begin
                wr_count <= wr_count + LW'(1);
                if (last)
                    done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_snapshot_writer.sv
// bram_snapshot_writer
// Captures a fixed number of valid stream samples into BRAM addresses
// 0..N-1 after arm (and optionally a trigger), then raises a sticky done.
// Ports:
//   axi_clock, rst_n           clock, async active-low reset
//   arm, abort, trig_en        control from the register block
//   ext_trig                   trigger level, qualified by din_valid
//   num_samples                capture length (0 or >depth = full depth)
//   din, din_valid             sample stream, no backpressure
//   bram_addr/bram_din/bram_we registered BRAM write port (1-cycle latency)
//   busy, done, wr_count       status
//   trig_timestamp             cycle count at first stored sample
//                              (only with SNAPSHOT_TIMESTAMP_EN defined)
module bram_snapshot_writer
    import snapshot_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  axi_clock,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trig_en,
    input  logic                  ext_trig,
    input  logic [ADDR_WIDTH:0]   num_samples,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  bram_we,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   wr_count
`ifdef SNAPSHOT_TIMESTAMP_EN
    ,
    output logic [31:0]           trig_timestamp
`endif
);

    logic take;

    snapshot_ctrl_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ctrl (
        .axi_clock   (axi_clock),
        .rst_n       (rst_n),
        .arm         (arm),
        .abort       (abort),
        .trig_en     (trig_en),
        .ext_trig    (ext_trig),
        .din_valid   (din_valid),
        .num_samples (num_samples),
        .take        (take),
        .busy        (busy),
        .done        (done),
        .wr_count    (wr_count)
    );

    // wr_count is still the pre-increment value here, so it is the address.
    always_ff @(posedge axi_clock or negedge rst_n) begin
        if (!rst_n) begin
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else begin
            bram_we <= take;
            if (take) begin
                bram_addr <= wr_count[ADDR_WIDTH-1:0];
                bram_din  <= din;
            end
        end
    end

`ifdef SNAPSHOT_TIMESTAMP_EN
    logic [31:0] cycle_q;

    always_ff @(posedge axi_clock or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q        <= '0;
            trig_timestamp <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (take && wr_count == '0)
                trig_timestamp <= cycle_q;
        end
    end
`endif

endmodule
